// File: rtl/simon_pkg.sv
// simon_pkg -- shared constants, types and helper functions for the SIMON
// 128/256 core.
//
// Contents:
//   WORD, ROUNDS, EXPAND_STEPS  fixed cipher geometry (64-bit words, 72 rounds)
//   Z4                          round-constant sequence z4, bit 0 = leftmost
//   state_t                     FSM state encoding used by simon
//   f_round()                   SIMON round function
//   key_fwd()/key_rev()         one forward / reverse key-schedule step
//   zidx_inc()/zidx_dec()       modulo-62 index stepping into Z4
//
// Optional feature macro: SIMON_DECRYPT_EN (consumed by simon and
// simon_key_sched; the package itself is identical in both builds).
package simon_pkg;

  localparam int WORD         = 64;
  localparam int ROUNDS       = 72;
  localparam int EXPAND_STEPS = 68;
  localparam int ZLEN         = 62;

  // Literal is written leftmost-first, so sequence element i is Z4[61-i].
  localparam logic [ZLEN-1:0] Z4 =
    62'b11010001111001101011011000100000010111000011001010010011101111;

  // Last values of the round / expansion counters.
  localparam logic [6:0] LAST_ROUND  = 7'(ROUNDS - 1);
  localparam logic [6:0] LAST_EXPAND = 7'(EXPAND_STEPS - 1);

  // The first reverse step of a decryption regenerates k67, which uses
  // z4[67 mod 62].
  localparam logic [5:0] ZIDX_DEC_START = 6'd5;

  typedef logic [WORD-1:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_ROUND  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  function automatic word_t rol(input word_t v, input int unsigned n);
    return (v << n) | (v >> (WORD - n));
  endfunction

  function automatic word_t ror(input word_t v, input int unsigned n);
    return (v >> n) | (v << (WORD - n));
  endfunction

  // f(x) = (x<<<1 & x<<<8) ^ (x<<<2)
  function automatic word_t f_round(input word_t v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  // Sequence element z4[idx], idx in 0..61.
  function automatic logic z_bit(input logic [5:0] idx);
    return Z4[6'd61 - idx];
  endfunction

  // Shared mixing term t of both schedule directions:
  // t = (k[i+3] >>> 3) ^ k[i+1]; t ^= t >>> 1
  function automatic word_t key_mix(input word_t k3, input word_t k1);
    word_t t;
    t = ror(k3, 3) ^ k1;
    return t ^ ror(t, 1);
  endfunction

  // k[i+4] from k[i], k[i+1], k[i+3]
  function automatic word_t key_fwd(input word_t k0, input word_t k1,
                                    input word_t k3, input logic z);
    return ~k0 ^ key_mix(k3, k1) ^ {{(WORD-1){1'b0}}, z} ^ 64'h3;
  endfunction

  // k[i] from k[i+4], k[i+3], k[i+1]
  function automatic word_t key_rev(input word_t k4, input word_t k3,
                                    input word_t k1, input logic z);
    return ~(k4 ^ key_mix(k3, k1) ^ {{(WORD-1){1'b0}}, z} ^ 64'h3);
  endfunction

  function automatic logic [5:0] zidx_inc(input logic [5:0] idx);
    return (idx == 6'(ZLEN - 1)) ? 6'd0 : idx + 6'd1;
  endfunction

  function automatic logic [5:0] zidx_dec(input logic [5:0] idx);
    return (idx == 6'd0) ? 6'(ZLEN - 1) : idx - 6'd1;
  endfunction

endpackage

// File: rtl/simon_if.sv
// simon_if -- host-side handshake and data bus of the SIMON core.
//
// Signals:
//   start  host -> core  start request (accepted only when idle or done)
//   ctrl   host -> core  1 = encrypt, 0 = decrypt
//   keys   host -> core  256-bit key {k3,k2,k1,k0}, k0 = keys[63:0]
//   pt     host -> core  input block {x,y}
//   ct     core -> host  result block {x,y}
//   done   core -> host  high while ct holds a valid result
//
// Modports: master (host side), slave (core side).
interface simon_if;
  logic         start;
  logic         ctrl;
  logic [255:0] keys;
  logic [127:0] pt;
  logic [127:0] ct;
  logic         done;

  modport master (output start, output ctrl, output keys, output pt,
                  input  ct,    input  done);

  modport slave  (input  start, input  ctrl, input  keys, input  pt,
                  output ct,    output done);
endinterface

// File: rtl/simon_key_sched.sv
// simon_key_sched -- on-the-fly SIMON 128/256 round-key generator.
//
// Holds a 4-word sliding window of the key schedule. Forward steps shift the
// window up by one key (k[i..i+3] -> k[i+1..i+4]); reverse steps shift it
// down (k[i+1..i+4] -> k[i..i+3]).
//
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-high reset, clears the window
//   load      in   load window from keys (k0 = keys[63:0])
//   keys      in   256-bit master key
//   step_fwd  in   perform one forward schedule step
//   step_rev  in   perform one reverse schedule step (SIMON_DECRYPT_EN only)
//   z         in   z4 sequence bit for the step being performed
//   key_enc   out  lowest window word, the encryption round key
//   key_dec   out  highest window word, the decryption round key
//                  (SIMON_DECRYPT_EN only)
//
// Macro SIMON_DECRYPT_EN adds the reverse step and the key_dec output.
module simon_key_sched
  import simon_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [255:0] keys,
  input  logic         step_fwd,
`ifdef SIMON_DECRYPT_EN
  input  logic         step_rev,
  output word_t        key_dec,
`endif
  input  logic         z,
  output word_t        key_enc
);

  // win_reg[0] is the oldest key of the window, win_reg[3] the newest.
  logic [3:0][WORD-1:0] win_reg;
  word_t                fwd_word;

  assign fwd_word = key_fwd(win_reg[0], win_reg[1], win_reg[3], z);
  assign key_enc  = win_reg[0];

`ifdef SIMON_DECRYPT_EN
  word_t rev_word;

  // Window currently holds k[i+1..i+4]; regenerate k[i].
  assign rev_word = key_rev(win_reg[3], win_reg[2], win_reg[0], z);
  assign key_dec  = win_reg[3];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_reg <= '0;
    end else if (load) begin
      win_reg <= keys;
    end else if (step_fwd) begin
      win_reg <= {fwd_word, win_reg[3], win_reg[2], win_reg[1]};
`ifdef SIMON_DECRYPT_EN
    end else if (step_rev) begin
      win_reg <= {win_reg[2], win_reg[1], win_reg[0], rev_word};
`endif
    end
  end

endmodule

// File: rtl/simon.sv
// simon -- iterative SIMON 128/256 block cipher core, one round per clock.
//
// Round keys are produced on the fly by simon_key_sched; no key RAM.
// Encryption: start accepted at edge N, result and done after edge N+72.
// Decryption: 68 forward schedule steps (EXPAND) bring the key window to
// k68..k71, then 72 rounds run backwards; result after edge N+140.
// ct only changes on entry to DONE, so the previous result stays visible
// while a new operation is running. done drops at the edge accepting the
// next start.
//
// Ports:
//   clk    in   clock, rising edge
//   res_n  in   asynchronous active-high reset (name inherited), clears all
//               state, including ct and done
//   bus    slave modport of simon_if (start, ctrl, keys, pt, ct, done)
//
// Macro SIMON_DECRYPT_EN: when defined, ctrl selects encrypt/decrypt and the
// EXPAND state plus reverse key schedule are built. When undefined, ctrl is
// ignored and every operation is an encryption.
module simon
  import simon_pkg::*;
(
  input  logic    clk,
  input  logic    res_n,
  simon_if.slave  bus
);

  state_t       state_reg;
  logic [6:0]   round_reg;   // round index, or step count while expanding
  logic [5:0]   zidx_reg;    // current position in z4 (mod 62)
  word_t        x_reg;
  word_t        y_reg;
  logic [127:0] ct_reg;
  logic         done_reg;

  logic         accept;
  logic         step_fwd;
  logic         z_cur;
  logic         round_last;
  word_t        key_enc;
  word_t        x_next;
  word_t        y_next;

`ifdef SIMON_DECRYPT_EN
  logic         dec_reg;     // operation in progress is a decryption
  logic         step_rev;
  word_t        key_dec;
`else
  logic         ctrl_unused;
  assign ctrl_unused = bus.ctrl;
`endif

  assign accept = bus.start && (state_reg == S_IDLE || state_reg == S_DONE);
  assign z_cur  = z_bit(zidx_reg);

`ifdef SIMON_DECRYPT_EN
  // Expansion always steps forward; rounds step in the direction of the
  // operation so the window always holds the key the next round needs.
  assign step_fwd   = (state_reg == S_EXPAND) ||
                      (state_reg == S_ROUND && !dec_reg);
  assign step_rev   = (state_reg == S_ROUND) && dec_reg;
  assign round_last = dec_reg ? (round_reg == 7'd0)
                              : (round_reg == LAST_ROUND);
`else
  assign step_fwd   = (state_reg == S_ROUND);
  assign round_last = (round_reg == LAST_ROUND);
`endif

  simon_key_sched u_key_sched (
    .clk      (clk),
    .rst      (res_n),
    .load     (accept),
    .keys     (bus.keys),
    .step_fwd (step_fwd),
`ifdef SIMON_DECRYPT_EN
    .step_rev (step_rev),
    .key_dec  (key_dec),
`endif
    .z        (z_cur),
    .key_enc  (key_enc)
  );

  // Next block value for the round in progress.
  always_comb begin
    x_next = y_reg ^ f_round(x_reg) ^ key_enc;
    y_next = x_reg;
`ifdef SIMON_DECRYPT_EN
    if (dec_reg) begin
      x_next = y_reg;
      y_next = x_reg ^ f_round(y_reg) ^ key_dec;
    end
`endif
  end

  always_ff @(posedge clk or posedge res_n) begin
    if (res_n) begin
      state_reg <= S_IDLE;
      round_reg <= '0;
      zidx_reg  <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      ct_reg    <= '0;
      done_reg  <= 1'b0;
`ifdef SIMON_DECRYPT_EN
      dec_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            x_reg     <= bus.pt[127:64];
            y_reg     <= bus.pt[63:0];
            round_reg <= '0;
            zidx_reg  <= '0;
            done_reg  <= 1'b0;
`ifdef SIMON_DECRYPT_EN
            dec_reg   <= ~bus.ctrl;
            state_reg <= bus.ctrl ? S_ROUND : S_EXPAND;
`else
            state_reg <= S_ROUND;
`endif
          end
        end

`ifdef SIMON_DECRYPT_EN
        S_EXPAND: begin
          if (round_reg == LAST_EXPAND) begin
            // Window now holds k68..k71; decryption starts at round 71.
            state_reg <= S_ROUND;
            round_reg <= LAST_ROUND;
            zidx_reg  <= ZIDX_DEC_START;
          end else begin
            round_reg <= round_reg + 7'd1;
            zidx_reg  <= zidx_inc(zidx_reg);
          end
        end
`endif

        S_ROUND: begin
          x_reg <= x_next;
          y_reg <= y_next;
          if (round_last) begin
            state_reg <= S_DONE;
            ct_reg    <= {x_next, y_next};
            done_reg  <= 1'b1;
          end
`ifdef SIMON_DECRYPT_EN
          if (dec_reg) begin
            round_reg <= round_reg - 7'd1;
            zidx_reg  <= zidx_dec(zidx_reg);
          end else begin
            round_reg <= round_reg + 7'd1;
            zidx_reg  <= zidx_inc(zidx_reg);
          end
`else
          round_reg <= round_reg + 7'd1;
          zidx_reg  <= zidx_inc(zidx_reg);
`endif
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.ct   = ct_reg;
  assign bus.done = done_reg;

endmodule

// File: tb/tb_simon.sv
// tb_simon -- directed, self-checking bench for the SIMON 128/256 core.
// Expected results are queued when an operation is launched and popped
// when the core raises done. Works with SIMON_DECRYPT_EN defined or not.
module tb_simon;

  localparam logic [255:0] KAT_KEY =
    256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] KAT_PT = 128'h74206e69206d6f6f_6d69732061207369;
  localparam logic [127:0] KAT_CT = 128'h8d2b5579afc8a3a0_3bf72a87efe7b868;
  localparam int ENC_LAT = 72;
  localparam int DEC_LAT = 140;
  localparam int MAX_WAIT = 400;

  logic clk = 1'b0;
  logic res_n;
  always #5 clk = ~clk;

  simon_if bus ();

  simon dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  typedef struct {
    string        tag;
    logic [127:0] ct;
    logic         chk_ct;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one operation, wait for done, compare against the queued
  // expectation. restart_at >= 0 re-pulses start at that cycle and checks
  // that ct still holds hold_exp.
  task automatic run_op(input string tag, input logic [255:0] k,
                        input logic [127:0] p, input logic c,
                        input logic [127:0] e, input logic chk,
                        input int lat, input int restart_at,
                        input logic [127:0] hold_exp,
                        output logic [127:0] got);
    exp_t item;
    int   cnt;
    item.tag = tag; item.ct = e; item.chk_ct = chk; item.lat = lat;
    sb_q.push_back(item);
    @(negedge clk);
    bus.keys = k; bus.pt = p; bus.ctrl = c; bus.start = 1'b1;
    @(negedge clk);
    // Inputs change after acceptance; the core must not care.
    bus.start = 1'b0; bus.keys = ~k; bus.pt = ~p; bus.ctrl = ~c;
    check({tag, "/done_clr"}, {127'b0, bus.done}, 128'd0);
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < MAX_WAIT) begin
      if (cnt == restart_at) begin
        bus.start = 1'b1;
        check({tag, "/ct_hold"}, bus.ct, hold_exp);
      end
      @(posedge clk);
      cnt++;
      @(negedge clk);
      bus.start = 1'b0;
    end
    item = sb_q.pop_front();
    check({item.tag, "/latency"}, 128'(cnt), 128'(item.lat));
    if (item.chk_ct) check({item.tag, "/ct"}, bus.ct, item.ct);
    got = bus.ct;
    $display("op %s ctrl=%0b ct=%h cycles=%0d", tag, c, got, cnt);
  endtask

  logic [127:0] res_ct;
  logic [127:0] prev_ct;

  initial begin
    res_n = 1'b1;
    bus.start = 1'b0; bus.ctrl = 1'b0; bus.keys = '0; bus.pt = '0;
    repeat (3) @(negedge clk);
    check("reset/ct", bus.ct, 128'd0);
    check("reset/done", {127'b0, bus.done}, 128'd0);
    res_n = 1'b0;

    // Known-answer encryption.
    run_op("kat_enc", KAT_KEY, KAT_PT, 1'b1, KAT_CT, 1'b1, ENC_LAT, -1,
           128'd0, res_ct);

`ifdef SIMON_DECRYPT_EN
    run_op("kat_dec", KAT_KEY, KAT_CT, 1'b0, KAT_PT, 1'b1, DEC_LAT, -1,
           128'd0, res_ct);
    prev_ct = KAT_PT;
`else
    // ctrl is ignored: still an encryption.
    run_op("enc_only", KAT_KEY, KAT_PT, 1'b0, KAT_CT, 1'b1, ENC_LAT, -1,
           128'd0, res_ct);
    prev_ct = KAT_CT;
`endif

    // Second start at cycle 10 is ignored; ct holds previous result.
    run_op("restart", KAT_KEY, KAT_PT, 1'b1, KAT_CT, 1'b1, ENC_LAT, 10,
           prev_ct, res_ct);

`ifdef SIMON_DECRYPT_EN
    // Round trips with all-zero and key = 1.
    run_op("rt0_enc", 256'd0, 128'd0, 1'b1, 128'd0, 1'b0, ENC_LAT, -1,
           128'd0, res_ct);
    run_op("rt0_dec", 256'd0, res_ct, 1'b0, 128'd0, 1'b1, DEC_LAT, -1,
           128'd0, res_ct);
    run_op("rt1_enc", 256'd1, 128'd0, 1'b1, 128'd0, 1'b0, ENC_LAT, -1,
           128'd0, res_ct);
    run_op("rt1_dec", 256'd1, res_ct, 1'b0, 128'd0, 1'b1, DEC_LAT, -1,
           128'd0, res_ct);
`endif

    // Reset at cycle 30 of an encryption aborts at once.
    @(negedge clk);
    bus.keys = KAT_KEY; bus.pt = KAT_PT; bus.ctrl = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (29) @(negedge clk);
    res_n = 1'b1;
    #1;
    check("abort/ct", bus.ct, 128'd0);
    check("abort/done", {127'b0, bus.done}, 128'd0);
    $display("op abort ct=%h done=%0b", bus.ct, bus.done);
    repeat (2) @(negedge clk);
    res_n = 1'b0;
    run_op("post_rst", KAT_KEY, KAT_PT, 1'b1, KAT_CT, 1'b1, ENC_LAT, -1,
           128'd0, res_ct);

    $display("last result %h", res_ct);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
